// File: rtl/spi_master.sv
// Single-frame SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One START pulse runs a complete CS/SCK/MOSI frame and returns the received word on DIN.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DOUT,
  output logic [WIDTH-1:0] DIN,
  output logic             SCK,
  output logic             CS,
  output logic             MOSI,
  input  logic             MISO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    din_d      = din_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;

    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        cs_d   = 1'b1;
        busy_d = 1'b0;
        if (START) begin
          tx_shift_d = DOUT;
          rx_shift_d = '0;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], MISO};
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = FINISH;
          end else begin
            // MOSI is the top bit of tx_shift, so it only moves on SCK falling edges
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      FINISH: begin
        cs_d       = 1'b1;
        tx_shift_d = '0;
        din_d      = rx_shift_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      din_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      din_q      <= din_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  assign SCK  = sck_q;
  assign CS   = cs_q;
  assign MOSI = tx_shift_q[WIDTH-1];
  assign DIN  = din_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master: one instance at CLK_DIV=1, one at CLK_DIV=3,
// each frame compared against a per-bit model of what an SPI mode-0 slave would see.
module tb_spi_master;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic         sel;
  logic         loop_en;
  logic         miso_drv;
  logic [W-1:0] dout;
  logic         miso;

  logic [W-1:0] din1, din3;
  logic         sck1, cs1, mosi1, busy1, done1;
  logic         sck3, cs3, mosi3, busy3, done3;

  logic [W-1:0] obs_din;
  logic         obs_sck, obs_cs, obs_mosi, obs_busy, obs_done;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  spi_master #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start & ~sel), .DOUT(dout), .DIN(din1),
    .SCK(sck1), .CS(cs1), .MOSI(mosi1), .MISO(miso), .BUSY(busy1), .DONE(done1)
  );

  spi_master #(.WIDTH(W), .CLK_DIV(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .START(start & sel), .DOUT(dout), .DIN(din3),
    .SCK(sck3), .CS(cs3), .MOSI(mosi3), .MISO(miso), .BUSY(busy3), .DONE(done3)
  );

  assign obs_din  = sel ? din3  : din1;
  assign obs_sck  = sel ? sck3  : sck1;
  assign obs_cs   = sel ? cs3   : cs1;
  assign obs_mosi = sel ? mosi3 : mosi1;
  assign obs_busy = sel ? busy3 : busy1;
  assign obs_done = sel ? done3 : done1;
  assign miso     = loop_en ? obs_mosi : miso_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode: 0 = MISO tied high, 1 = MISO looped from MOSI, 2 = random MISO per cycle
  task automatic run_frame(input logic [W-1:0] d, input int div, input int mode,
                           input bit mid_start, input bit mid_dout);
    logic [W-1:0] got_mosi = '0;
    logic [W-1:0] exp_din  = '0;
    int rises = 0, cs_low = 0, busy_cnt = 0, dones = 0, done_at = -1;
    int phase_bad = 0, unstable = 0, run_len = 0;
    logic prev_sck, prev_mosi, last_miso;
    dout      = d;
    loop_en   = (mode == 1);
    miso_drv  = (mode == 0) ? 1'b1 : 1'($urandom);
    last_miso = miso_drv;
    prev_sck  = 1'b0;
    prev_mosi = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2 * W * div + 20; n++) begin
      if (!obs_cs) cs_low++;
      if (obs_busy) busy_cnt++;
      if (obs_done) begin
        dones++;
        done_at = n;
      end
      if (obs_sck != prev_sck) begin
        if (run_len != div) phase_bad++;
        run_len = 0;
      end
      run_len++;
      if (obs_sck && !prev_sck) begin
        rises++;
        got_mosi = {got_mosi[W-2:0], obs_mosi};
        if (obs_mosi !== prev_mosi) unstable++;
        exp_din = {exp_din[W-2:0], (mode == 1) ? prev_mosi : last_miso};
      end
      if (done_at >= 0 && n >= done_at + 3) break;
      prev_sck  = obs_sck;
      prev_mosi = obs_mosi;
      if (mode == 2) miso_drv = 1'($urandom);
      last_miso = miso_drv;
      if (mid_dout && n == 3) dout = '0;
      start = mid_start && (n == 6);
      tick();
    end
    start = 1'b0;
    check("sck_rises", rises, W);
    check("mosi_bits", got_mosi, d);
    check("cs_low_cycles", cs_low, 2 * W * div + 1);
    check("busy_cycles", busy_cnt, 2 * W * div + 1);
    check("done_pulses", dones, 1);
    check("sck_phase_errs", phase_bad, 0);
    check("mosi_unstable", unstable, 0);
    check("din_model", obs_din, exp_din);
    if (mode == 0) check("din_all_ones", obs_din, {W{1'b1}});
    if (mode == 1) check("din_loopback", obs_din, d);
    $display("frame div=%0d mode=%0d dout=%02h din=%02h expect=%02h cs_low=%0d",
             div, mode, d, obs_din, exp_din, cs_low);
  endtask

  initial begin
    int d1, d2, cs_high, rst_dones;
    RST_N    = 1'b0;
    start    = 1'b0;
    sel      = 1'b0;
    loop_en  = 1'b0;
    miso_drv = 1'b0;
    dout     = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_sck", obs_sck, 0);
    check("rst_cs", obs_cs, 1);
    check("rst_mosi", obs_mosi, 0);
    check("rst_din", obs_din, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_done", obs_done, 0);
    #2 RST_N = 1'b1;
    tick();

    run_frame(8'h5D, 1, 0, 1'b0, 1'b0);
    run_frame(8'hA5, 1, 1, 1'b0, 1'b0);
    run_frame(8'h3C, 1, 1, 1'b0, 1'b0);
    sel = 1'b1;
    run_frame(8'h81, 3, 0, 1'b0, 1'b0);
    sel = 1'b0;
    run_frame(8'h5D, 1, 2, 1'b1, 1'b0);
    run_frame(8'h5D, 1, 0, 1'b0, 1'b1);

    // START held high: frames separated by exactly one CS-high IDLE cycle
    loop_en  = 1'b0;
    miso_drv = 1'b1;
    dout     = 8'h96;
    start    = 1'b1;
    d1 = -1;
    d2 = -1;
    cs_high = 0;
    tick();
    for (int n = 0; n < 60; n++) begin
      if (obs_done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (obs_cs && d2 < 0) cs_high++;
      if (d2 >= 0) break;
      tick();
    end
    start = 1'b0;
    check("b2b_first_done", d1, 2 * W + 1);
    check("b2b_done_gap", d2 - d1, 2 * W + 2);
    check("b2b_cs_high", cs_high, 1);
    repeat (3) tick();
    check("b2b_no_third", obs_cs, 1);
    $display("frame back-to-back dout=96 done1=%0d done2=%0d cs_high=%0d", d1, d2, cs_high);

    for (int i = 0; i < 6; i++) begin
      sel = 1'($urandom);
      run_frame(W'($urandom), sel ? 3 : 1, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
    sel = 1'b0;

    // asynchronous reset in the middle of a frame
    run_frame(8'hC3, 1, 1, 1'b0, 1'b0);
    dout  = 8'h7E;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 RST_N = 1'b0;
    #1;
    check("abort_sck", obs_sck, 0);
    check("abort_cs", obs_cs, 1);
    check("abort_mosi", obs_mosi, 0);
    check("abort_din", obs_din, 0);
    check("abort_busy", obs_busy, 0);
    rst_dones = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (obs_done) rst_dones++;
    end
    #2 RST_N = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (obs_done) rst_dones++;
    end
    check("abort_no_done", rst_dones, 0);
    check("abort_din_held", obs_din, 0);
    check("abort_cs_idle", obs_cs, 1);
    $display("frame reset-abort dout=7E din=%02h", obs_din);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name:
spi_master

Overview:
- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- A one-cycle START pulse loads the parallel byte DOUT and drives the full CS/SCK/MOSI frame.
- MISO is sampled during the frame; the received byte is presented on DIN when the frame ends.
- Sits between a host-side controller and one external SPI slave. CS is dedicated to that slave.

Parameters:
- WIDTH, 8, bits per frame and width of DOUT/DIN; must be at least 2.
- CLK_DIV, 1, number of CLK cycles per SCK half-period; must be at least 1. SCK frequency is CLK/(2*CLK_DIV).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  starts a frame; sampled only in IDLE.
- DOUT  input  WIDTH  byte to transmit; latched in the cycle START is accepted.
- DIN  output  WIDTH  last received byte; registered.
- SCK  output  1  SPI clock; idles low.
- CS  output  1  active-low chip select; idles high.
- MOSI  output  1  serial data out, MSB first.
- MISO  input  1  serial data in.
- BUSY  output  1  high from START acceptance until the cycle before DONE.
- DONE  output  1  one-cycle pulse when DIN is updated.

Behaviour:
- Reset (RST_N=0, asynchronous) forces:
  - SCK=0, CS=1, MOSI=0, DIN=0, BUSY=0, DONE=0;
  - state IDLE; all counters and shift registers cleared.
- Reset mid-frame aborts the frame immediately. DIN is not updated.
- States are IDLE, XFER and FINISH. All outputs are registered.
- IDLE:
  - SCK=0, CS=1, MOSI=0, DONE=0.
  - When START=1 at a CLK edge: tx_shift<=DOUT, MOSI<=DOUT[WIDTH-1], CS<=0, BUSY<=1, bit_cnt<=0, div_cnt<=0, go to XFER.
- XFER:
  - div_cnt counts CLK cycles. When div_cnt reaches CLK_DIV-1, it resets and SCK toggles.
  - On SCK 0->1: rx_shift <= {rx_shift[WIDTH-2:0], MISO}. MISO is sampled in the same CLK cycle SCK is driven high.
  - On SCK 1->0 with bit_cnt < WIDTH-1: tx_shift shifts left; MOSI<=next bit; bit_cnt++.
  - On SCK 1->0 with bit_cnt = WIDTH-1: go to FINISH. SCK ends low.
- FINISH (one cycle), then IDLE:
  - CS<=1, MOSI<=0, DIN<=rx_shift (complete byte), DONE<=1 for exactly one cycle, BUSY<=0.
- Timing with START accepted at edge 0 and CLK_DIV=1:
  - SCK rises at edges 1,3,…,2W-1 and falls at 2,4,…,2W.
  - CS rises and DONE pulses after edge 2W+1.
  - For W=8, CS is low for 17 CLK cycles.
  - General frame length: 2*WIDTH*CLK_DIV+1 cycles.
- MOSI changes only while SCK is low, or at CS assertion. It is stable across every SCK rising edge.
- START while BUSY or in FINISH is ignored. It is not queued.
- START held high: a new frame begins in the IDLE cycle after FINISH. There is at least one IDLE cycle with CS=1 between frames.
- DOUT changes after acceptance do not affect the frame in progress.
- DIN holds its value between frames and changes only in FINISH.

Test Plan:
- Reset: RST_N low mid-frame -> SCK=0, CS=1, MOSI=0, DIN=0, BUSY=0 immediately. No DONE.
- Basic transmit: DOUT=0x5D, MISO tied 1, one-cycle START -> MOSI is 0,1,0,1,1,1,0,1 at the 8 SCK rising edges. CS is low 17 cycles. DONE pulses once. DIN=0xFF.
- Loopback: MISO tied to MOSI, DOUT=0xA5 -> DIN=0xA5. Then DOUT=0x3C -> DIN=0x3C.
- Divider: CLK_DIV=3, DOUT=0x81 -> SCK high and low phases of 3 CLK each. 8 rising edges. Frame length 49 cycles.
- START during BUSY: a second pulse mid-frame -> ignored, exactly 8 SCK pulses, one DONE. START held high -> back-to-back frames with one CS-high IDLE cycle between them.
- DOUT changed mid-frame from 0x5D to 0x00 -> MOSI still shifts 0x5D.
